// File: rtl/tilemap_fetcher.sv
// Two-layer tilemap fetcher: per 8-pixel period fetches layer B then layer A
// (VRAM entry, then GFX ROM line) and drives each layer's pixel shifter.
module tilemap_fetcher (
  input  logic        i_EMU_MCLK,
  input  logic        i_EMU_INITRST_n,
  input  logic        i_EMU_CLK6MPCEN_n,
  input  logic [8:0]  i_ABS_H,
  input  logic [7:0]  i_ABS_V,
  input  logic        i_HBLANK_n,
  input  logic [8:0]  i_A_SCROLLX,
  input  logic [8:0]  i_B_SCROLLX,
  input  logic [7:0]  i_A_SCROLLY,
  input  logic [7:0]  i_B_SCROLLY,
  output logic [11:0] o_VRAM_ADDR,
  input  logic [15:0] i_VRAM_DATA,
  output logic [12:0] o_GFXROM_ADDR,
  output logic        o_GFXROM_RD_n,
  output logic [1:0]  o_A_MODE,
  output logic [1:0]  o_B_MODE,
  output logic        o_AFF,
  output logic        o_BFF,
  output logic [3:0]  o_A_PALETTE,
  output logic [3:0]  o_B_PALETTE
);

  logic       ce;
  logic [2:0] phase, nxt_phase;
  logic [1:0] step;
  logic       lyr_b;
  logic [8:0] sx;
  logic [7:0] sy;
  logic [7:0] y_sum;
  logic [5:0] col;
  logic [2:0] loadph_a, loadph_b;
  logic       load_a, load_b;
  logic       ff_a_nxt, ff_b_nxt;

  // Slot bookkeeping; attribute words are kept as {palette[3:0], xflip}.
  logic       slot_act;
  logic [2:0] fine_y_p0;
  logic [4:0] pend_p1;
  logic [4:0] latch_a, latch_b;
  logic [3:0] pal_a_p0, pal_a_p1, pal_a_p2, pal_a_p3;

  function automatic logic [1:0] mode_sel(input logic ld, input logic blank_n, input logic ff);
    if (ld)       return 2'b11;
    if (!blank_n) return 2'b00;
    return ff ? 2'b01 : 2'b10;
  endfunction

  always_comb begin
    ce        = ~i_EMU_CLK6MPCEN_n;
    phase     = i_ABS_H[2:0];
    nxt_phase = phase + 3'd1;
    step      = phase[1:0];
    lyr_b     = ~phase[2];
    sx        = lyr_b ? i_B_SCROLLX : i_A_SCROLLX;
    sy        = lyr_b ? i_B_SCROLLY : i_A_SCROLLY;
    y_sum     = i_ABS_V + sy;
    col       = i_ABS_H[8:3] + 6'd1 + sx[8:3] + {5'd0, (sx[2:0] == 3'd7)};
    loadph_a  = i_A_SCROLLX[2:0];
    loadph_b  = i_B_SCROLLX[2:0] + 3'd4;
    load_a    = (phase == loadph_a);
    load_b    = (phase == loadph_b);
    // Mode for the next phase must see the flip that this edge loads.
    ff_a_nxt  = load_a ? latch_a[0] : o_AFF;
    ff_b_nxt  = load_b ? latch_b[0] : o_BFF;
  end

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      o_VRAM_ADDR   <= '0;
      o_GFXROM_ADDR <= '0;
      o_GFXROM_RD_n <= 1'b1;
      o_A_MODE      <= '0;
      o_B_MODE      <= '0;
      o_AFF         <= 1'b0;
      o_BFF         <= 1'b0;
      o_A_PALETTE   <= '0;
      o_B_PALETTE   <= '0;
      slot_act      <= 1'b0;
      fine_y_p0     <= '0;
      pend_p1       <= '0;
      latch_a       <= '0;
      latch_b       <= '0;
      pal_a_p0      <= '0;
      pal_a_p1      <= '0;
      pal_a_p2      <= '0;
      pal_a_p3      <= '0;
    end else if (ce) begin
      // Fetch stage p0: VRAM address and fine Y at the slot boundary
      case (step)
        2'd0: begin
          o_VRAM_ADDR <= {lyr_b, y_sum[7:3], col};
          fine_y_p0   <= y_sum[2:0];
          slot_act    <= 1'b1;
        end
        // Fetch stage p1: VRAM word captured, ROM read issued for s2-s3
        2'd1: begin
          if (slot_act) begin
            pend_p1       <= {i_VRAM_DATA[15:12], i_VRAM_DATA[10]};
            o_GFXROM_ADDR <= {i_VRAM_DATA[9:0], fine_y_p0 ^ {3{i_VRAM_DATA[11]}}};
            o_GFXROM_RD_n <= 1'b0;
          end
        end
        2'd2: ;
        // Fetch stage p2: attributes move to the layer latch
        2'd3: begin
          o_GFXROM_RD_n <= 1'b1;
          if (slot_act) begin
            if (lyr_b) latch_b <= pend_p1;
            else       latch_a <= pend_p1;
          end
        end
        default: ;
      endcase

      o_A_MODE <= mode_sel(nxt_phase == loadph_a, i_HBLANK_n, ff_a_nxt);
      o_B_MODE <= mode_sel(nxt_phase == loadph_b, i_HBLANK_n, ff_b_nxt);

      if (load_a) begin
        o_AFF    <= latch_a[0];
        pal_a_p0 <= latch_a[4:1];
      end
      if (load_b) begin
        o_BFF       <= latch_b[0];
        o_B_PALETTE <= latch_b[4:1];
      end

      // Palette A pipeline p0..p3: output lands 4 enables after the load
      pal_a_p1    <= pal_a_p0;
      pal_a_p2    <= pal_a_p1;
      pal_a_p3    <= pal_a_p2;
      o_A_PALETTE <= pal_a_p3;
    end
  end

endmodule

// File: tb/tb_tilemap_fetcher.sv
// Directed bench for tilemap_fetcher: H counter stepped by the bench, one
// enable every other MCLK, outputs sampled 1 time unit after the edge.
module tb_tilemap_fetcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen_n;
  logic [8:0]  h;
  logic [7:0]  v;
  logic        hblank_n;
  logic [8:0]  a_sx, b_sx;
  logic [7:0]  a_sy, b_sy;
  logic [11:0] vram_addr;
  logic [15:0] vram_data;
  logic [12:0] rom_addr;
  logic        rom_rd_n;
  logic [1:0]  a_mode, b_mode;
  logic        aff, bff;
  logic [3:0]  a_pal, b_pal;
  logic [15:0] a_word, b_word;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign vram_data = vram_addr[11] ? b_word : a_word;

  tilemap_fetcher dut (
    .i_EMU_MCLK       (clk),
    .i_EMU_INITRST_n  (rst_n),
    .i_EMU_CLK6MPCEN_n(cen_n),
    .i_ABS_H          (h),
    .i_ABS_V          (v),
    .i_HBLANK_n       (hblank_n),
    .i_A_SCROLLX      (a_sx),
    .i_B_SCROLLX      (b_sx),
    .i_A_SCROLLY      (a_sy),
    .i_B_SCROLLY      (b_sy),
    .o_VRAM_ADDR      (vram_addr),
    .i_VRAM_DATA      (vram_data),
    .o_GFXROM_ADDR    (rom_addr),
    .o_GFXROM_RD_n    (rom_rd_n),
    .o_A_MODE         (a_mode),
    .o_B_MODE         (b_mode),
    .o_AFF            (aff),
    .o_BFF            (bff),
    .o_A_PALETTE      (a_pal),
    .o_B_PALETTE      (b_pal)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One enabled edge, then one idle edge (state must hold across it).
  task automatic en_step();
    cen_n = 1'b0;
    @(posedge clk); #1;
    cen_n = 1'b1;
    h = h + 9'd1;
    @(posedge clk); #1;
  endtask

  task automatic en_n(input int n);
    for (int i = 0; i < n; i++) en_step();
  endtask

  task automatic do_reset(input logic [8:0] h0);
    rst_n = 1'b0;
    cen_n = 1'b1;
    h     = h0;
    repeat (2) @(posedge clk);
    #1;
    cen_n = 1'b0;
    @(posedge clk); #1;
    cen_n = 1'b1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cen_n = 1'b1; h = '0; v = '0; hblank_n = 1'b1;
    a_sx = '0; b_sx = '0; a_sy = '0; b_sy = '0;
    a_word = 16'h5C07; b_word = 16'h3000;

    // Reset held with enables running
    cen_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vram_addr", {4'd0, vram_addr}, 16'h000);
    chk("rst_rom_rd_n",  {15'd0, rom_rd_n}, 16'h1);
    chk("rst_rom_addr",  {3'd0, rom_addr},  16'h000);
    chk("rst_modes",     {12'd0, a_mode, b_mode}, 16'h0);
    chk("rst_flips",     {14'd0, aff, bff}, 16'h0);
    chk("rst_pals",      {8'd0, a_pal, b_pal}, 16'h00);

    // Basic fetch, load and palette alignment
    do_reset(9'h000);
    @(posedge clk); #1;
    chk("hold_no_enable", {4'd0, vram_addr}, 16'h000);
    en_step();
    chk("b_vram_addr",   {4'd0, vram_addr}, 16'h801);
    chk("a_mode_shl",    {14'd0, a_mode}, 16'h2);
    en_step();
    chk("rd_low_s2",     {15'd0, rom_rd_n}, 16'h0);
    en_n(2);
    chk("rd_high_s0",    {15'd0, rom_rd_n}, 16'h1);
    chk("b_mode_load",   {14'd0, b_mode}, 16'h3);
    en_step();
    chk("a_vram_addr",   {4'd0, vram_addr}, 16'h001);
    chk("b_pal_at_load", {12'd0, b_pal}, 16'h3);
    en_step();
    chk("a_rom_addr",    {3'd0, rom_addr}, 16'h03F);
    en_n(2);
    chk("a_mode_load",   {14'd0, a_mode}, 16'h3);
    en_step();
    chk("a_ff_loaded",   {15'd0, aff}, 16'h1);
    chk("a_mode_shr",    {14'd0, a_mode}, 16'h1);
    chk("b_addr_per1",   {4'd0, vram_addr}, 16'h802);
    en_n(3);
    chk("a_pal_early",   {12'd0, a_pal}, 16'h0);
    en_step();
    chk("a_pal_4en",     {12'd0, a_pal}, 16'h5);

    // Fine scroll 7: column bump and load coinciding with the latch write
    a_sx = 9'h007;
    do_reset(9'h010);
    en_n(4);
    en_step();
    chk("sx7_a_addr",    {4'd0, vram_addr}, 16'h004);
    en_n(2);
    chk("sx7_mode_load", {14'd0, a_mode}, 16'h3);
    en_step();
    chk("sx7_old_latch", {15'd0, aff}, 16'h0);
    chk("sx7_mode_after",{14'd0, a_mode}, 16'h2);
    en_n(8);
    chk("sx7_new_latch", {15'd0, aff}, 16'h1);
    a_sx = '0;

    // Y scroll wrap with yflip
    v = 8'hFC; b_sy = 8'h08; b_word = 16'h0955;
    do_reset(9'h000);
    en_step();
    chk("ywrap_addr",    {4'd0, vram_addr}, 16'h801);
    en_step();
    chk("yflip_rom",     {3'd0, rom_addr}, 16'hAAB);
    v = '0; b_sy = '0;

    // Column wrap and blanking
    hblank_n = 1'b0;
    do_reset(9'h1F8);
    en_step();
    chk("col_wrap_addr", {4'd0, vram_addr}, 16'h800);
    chk("blank_modes",   {12'd0, a_mode, b_mode}, 16'h0);
    en_n(3);
    chk("blank_b_load",  {12'd0, a_mode, b_mode}, 16'h3);
    en_step();
    chk("col_wrap_a",    {4'd0, vram_addr}, 16'h000);
    chk("blank_b_hold",  {14'd0, b_mode}, 16'h0);
    en_n(3);
    chk("blank_a_load",  {14'd0, a_mode}, 16'h3);
    hblank_n = 1'b1;

    // Reset mid-fetch and restart at the next slot boundary
    b_word = 16'h3400;
    do_reset(9'h000);
    en_n(6);
    chk("mid_rd_low",    {15'd0, rom_rd_n}, 16'h0);
    chk("mid_b_state",   {11'd0, b_pal, bff}, 16'h7);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd",    {15'd0, rom_rd_n}, 16'h1);
    chk("mid_rst_addr",  {4'd0, vram_addr}, 16'h000);
    chk("mid_rst_b",     {11'd0, b_pal, bff}, 16'h0);
    en_step();
    rst_n = 1'b1;
    en_step();
    chk("restart_addr0", {4'd0, vram_addr}, 16'h000);
    chk("restart_rd",    {15'd0, rom_rd_n}, 16'h1);
    en_step();
    chk("restart_addr",  {4'd0, vram_addr}, 16'h802);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tilemap_fetcher.md
TILEMAP_FETCHER -- requirements
Module: tilemap_fetcher

Interface
REQ-001 SHALL provide these ports (name  direction  width  meaning), clock and reset first:
 i_EMU_MCLK  in  1  master clock, the only clock; all state on its rising edge.
 i_EMU_INITRST_n  in  1  reset, asynchronous, active-low.
 i_EMU_CLK6MPCEN_n  in  1  pixel enable, active-low; an "enable" means one MCLK edge with this signal low.
 i_ABS_H  in  9  horizontal counter; phase = i_ABS_H[2:0], tile period = i_ABS_H[8:3].
 i_ABS_V  in  8  vertical counter.
 i_HBLANK_n  in  1  low during horizontal blank.
 i_A_SCROLLX / i_B_SCROLLX  in  9  layer X scroll.
 i_A_SCROLLY / i_B_SCROLLY  in  8  layer Y scroll.
 o_VRAM_ADDR  out  12  {layer (A=0, B=1), row[4:0], col[5:0]}.
 i_VRAM_DATA  in  16  [9:0] code, [10] xflip, [11] yflip, [15:12] palette.
 o_GFXROM_ADDR  out  13  {code[9:0], line[2:0]}.
 o_GFXROM_RD_n  out  1  ROM read strobe, active-low.
 o_A_MODE / o_B_MODE  out  2  shift-register command: 00 hold, 01 shift right, 10 shift left, 11 load.
 o_AFF / o_BFF  out  1  X flip of the tile currently in the shifter.
 o_A_PALETTE / o_B_PALETTE  out  4  palette, aligned to the pixel outputs.

Function
REQ-002 SHALL perform all state updates only on enables; between enables all state SHALL hold.
REQ-003 SHALL fetch layer B in slot phases 0-3 and layer A in slot phases 4-7; slot step s = phase mod 4.
REQ-004 At s0 SHALL register o_VRAM_ADDR; SHALL sample i_VRAM_DATA at the s1 enable into a pending register.
REQ-005 At s2-s3 SHALL drive o_GFXROM_RD_n=0 (1 otherwise) and o_GFXROM_ADDR={code, fineY XOR {3{yflip}}}.
REQ-006 SHALL copy pending attributes to an attribute latch at the phase-3 enable (B) and the phase-7 enable (A).
REQ-007 Y: sum = (i_ABS_V + SCROLLY) mod 256; row = sum[7:3]; fineY = sum[2:0].
REQ-008 X: col = (H[8:3] + 1 + SCROLLX[8:3] + (SCROLLX[2:0]==7 ? 1 : 0)) mod 64.
REQ-009 Load phase: LOADPH_A = i_A_SCROLLX[2:0]; LOADPH_B = (i_B_SCROLLX[2:0] + 4) mod 8.
REQ-010 The x_MODE signal sampled at the enable where phase == LOADPH_x SHALL be 11, including during blank.
REQ-011 At other enables x_MODE SHALL be 01 if the current xFF=1, else 10; when i_HBLANK_n=0 it SHALL be 00.
REQ-012 At the load enable SHALL update o_xFF from the latched xflip; o_B_PALETTE SHALL update in the same enable.
REQ-013 o_A_PALETTE SHALL update exactly 4 enables after the A load enable, via a 4-stage pipeline.
REQ-014 A load coinciding with its latch-write enable SHALL use the latch value from before that edge.
REQ-015 Mode outputs SHALL be registered, computed by look-ahead on the next phase; scroll inputs are sampled at s0 for the fetch and at the load enable for mode.

Reset
REQ-016 Reset low SHALL immediately set every output and all internal registers to zero, except o_GFXROM_RD_n=1.
REQ-017 After reset release, fetching SHALL start only at the next slot boundary (phase 0 or 4); any partial slot is discarded.
REQ-018 Reset asserted mid-fetch SHALL abort the fetch with no partial latch update.

Verification
REQ-019 Reset held, clocks running -> o_VRAM_ADDR=0, o_GFXROM_RD_n=1, modes=00, flips=0, palettes=0.
REQ-020 Scrolls=0, V=0, H period 0 -> o_VRAM_ADDR=0x801 at phase 0 and 0x001 at phase 4. i_VRAM_DATA=0x5C07 for A -> o_GFXROM_ADDR=0x03F. Next period: A mode=11 at phase 0, then 01; o_AFF=1; o_A_PALETTE=5 after 4 enables.
REQ-021 i_A_SCROLLX=0x007, H=0x010 -> A fetch addr 0x004; A load at phase 7 takes the prior latch value.
REQ-022 V=0xFC, i_B_SCROLLY=0x08 -> B row 0, fineY 4; yflip=1 -> ROM line 3.
REQ-023 H[8:3]=63, scroll 0 -> col wraps to 0; i_HBLANK_n=0 -> modes 00 except load enables (11).
REQ-024 Reset pulsed at phase 5 -> outputs zero at once; after release the first VRAM address appears at the next phase 0 or 4.
